ir_queue: RTL
=============

# ir_queue

Parametrised instruction buffer and field decoder for the lc3b datapath. It sits between the fetch stage and decode/control and holds up to DEPTH fetched instruction words with their PCs in a FIFO. It presents the head entry already split into opcode, register and offset fields, with offsets extended to lc3b_word width. Valid/ready handshakes on both sides let fetch run ahead of execute, and a flush discards all buffered entries on a taken branch or trap.

## Interface
- DEPTH, 4: number of entries; power of two, ≥ 2.
- SEXT, 1: 1 = offset5/6/9/11 sign-extended to 16 bits; 0 = zero-extended.
- clk  in  1  clock, all state on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous; empties the queue.
- in_valid  in  1  fetch offers a word.
- in_ready  out  1  queue accepts a word this cycle.
- in_word  in  16  instruction word (lc3b_word).
- in_pc  in  16  PC of in_word.
- out_valid  out  1  head entry valid.
- out_ready  in  1  consumer takes the head this cycle.
- out_pc  out  16  PC of the head entry.
- opcode  out  4  head[15:12] as lc3b_opcode.
- dest, src1, src2  out  3 each  head[11:9], head[8:6], head[2:0].
- imm_mode  out  1  head[5] (register/immediate select).
- offset4  out  16  head[3:0], always zero-extended (shift amount).
- offset8  out  16  head[7:0], always zero-extended (trap vector).
- offset5, offset6, offset9, offset11  out  16 each  extended per SEXT.
- count  out  $clog2(DEPTH+1)  current occupancy.

## Operation
- Push: in_valid && in_ready. Pop: out_valid && out_ready.
- in_ready = (count != DEPTH) && !flush. When full there is no write-through, even if a pop occurs in the same cycle.
- out_valid = (count != 0).
- Push and pop in the same cycle (non-full, non-empty): count unchanged, both pointers advance.
- Pop while empty is ignored. A push offered while in_ready = 0 is ignored and must be held by fetch.
- Flush has priority over everything: count ← 0, rd_ptr ← wr_ptr ← 0. A same-cycle push or pop has no effect.
- Pointers are $clog2(DEPTH) bits wide and wrap naturally. Full and empty are derived from count, not from pointer compare.
- All decoded outputs come combinationally from the head storage entry. When out_valid = 0, every decoded output and out_pc drive 0.
- Sign extension replicates the top bit of the field into bits 15 down to the field width.

## Timing
- Reset (rst_n low, asynchronous): count = 0, pointers = 0, out_valid = 0, all decoded outputs and out_pc = 0, in_ready = 1 (unless flush is high). Storage contents need no reset.
- Reset asserted mid-operation discards all entries immediately, without waiting for a clock edge.
- Push-to-out_valid latency: 1 cycle. A word accepted at edge N is visible at the head after edge N. There is no same-cycle bypass.
- A pop at edge N exposes the next entry after edge N, so back-to-back pops sustain 1 instruction per cycle.
- flush asserted in cycle N: out_valid = 0 and count = 0 after edge N. in_ready is 0 during cycle N.

## Structure
- lc3b_types additions:
  - lc3b_ir_fields struct (opcode, dest, src1, src2, imm_mode, offset4, offset5, offset6, offset8, offset9, offset11).
  - lc3b_word used for in_word, in_pc and storage.
- Sub-module ir_decode (parameter SEXT): combinational, lc3b_word in → lc3b_ir_fields out. It is instantiated once on the head entry.
- The FIFO (storage arrays, pointers, count) lives in ir_queue itself.

## Test plan
- Reset then push 0x1283 at pc 0x3000 → one cycle later: out_valid = 1, opcode = 0x1, dest = 1, src1 = 2, src2 = 3, imm_mode = 0, out_pc = 0x3000, count = 1.
- SEXT = 1, push 0x0FFF → offset9 = 0xFFFF, offset11 = 0xFFFF, dest = 7. With SEXT = 0 the same word gives offset9 = 0x01FF.
- Push 0x62BF (LDR R1,R2,-1) → offset6 = 0xFFFF, offset5 = 0xFFFF, offset4 = 0x000F, offset8 = 0x00BF.
- DEPTH = 4 with out_ready = 0: push 5 words back-to-back → in_ready drops after the 4th, count = 4, the 5th is held. Then assert out_ready and keep pushing → words emerge in order at 1 per cycle, pointer wrap-around is correct, and the held word is accepted only after the first pop frees an entry.
- Queue with 3 entries, flush asserted together with in_valid and out_ready → next cycle count = 0, out_valid = 0, all fields 0. The next push appears with 1-cycle latency.
- rst_n pulsed low between clock edges with 2 entries → out_valid and count go to 0 immediately, before the next edge, and in_ready = 1.

Source files
------------

// File: rtl/ir_queue_pkg.sv
// Shared lc3b datapath types used by the instruction queue and its field decoder.
package ir_queue_pkg;

    typedef logic [15:0] lc3b_word;
    typedef logic [3:0]  lc3b_opcode;
    typedef logic [2:0]  lc3b_reg;

    // Instruction fields split out of one lc3b word; offsets already widened to a word.
    typedef struct packed {
        lc3b_opcode opcode;
        lc3b_reg    dest;
        lc3b_reg    src1;
        lc3b_reg    src2;
        logic       imm_mode;
        lc3b_word   offset4;
        lc3b_word   offset5;
        lc3b_word   offset6;
        lc3b_word   offset8;
        lc3b_word   offset9;
        lc3b_word   offset11;
    } lc3b_ir_fields;

    // Keeps the low 'width' bits of raw; the upper bits copy raw[width-1] when sext is set, else 0.
    function automatic lc3b_word ext_field(input lc3b_word raw, input int unsigned width,
                                           input logic sext);
        lc3b_word res;
        res = '0;
        for (int unsigned i = 0; i < 16; i++) begin
            if (i < width)
                res[i] = raw[i];
            else
                res[i] = sext & raw[width-1];
        end
        return res;
    endfunction

endpackage

// File: rtl/ir_queue_decode.sv
// Combinational splitter turning one lc3b instruction word into its named fields.
module ir_decode
    import ir_queue_pkg::*;
#(
    parameter logic SEXT = 1'b1
) (
    input  lc3b_word      word,
    output lc3b_ir_fields fields
);

    // Slice the word; shift amount and trap vector are never sign-extended.
    always_comb begin
        fields          = '0;
        fields.opcode   = word[15:12];
        fields.dest     = word[11:9];
        fields.src1     = word[8:6];
        fields.src2     = word[2:0];
        fields.imm_mode = word[5];
        fields.offset4  = ext_field(word, 4, 1'b0);
        fields.offset8  = ext_field(word, 8, 1'b0);
        fields.offset5  = ext_field(word, 5, SEXT);
        fields.offset6  = ext_field(word, 6, SEXT);
        fields.offset9  = ext_field(word, 9, SEXT);
        fields.offset11 = ext_field(word, 11, SEXT);
    end

endmodule

// File: rtl/ir_queue.sv
// Instruction buffer between fetch and decode: FIFO of (word, pc) with a decoded head view.
module ir_queue
    import ir_queue_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter logic        SEXT  = 1'b1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       flush,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [15:0]                in_word,
    input  logic [15:0]                in_pc,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [15:0]                out_pc,
    output logic [3:0]                 opcode,
    output logic [2:0]                 dest,
    output logic [2:0]                 src1,
    output logic [2:0]                 src2,
    output logic                       imm_mode,
    output logic [15:0]                offset4,
    output logic [15:0]                offset8,
    output logic [15:0]                offset5,
    output logic [15:0]                offset6,
    output logic [15:0]                offset9,
    output logic [15:0]                offset11,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);

    lc3b_word      word_mem [DEPTH];
    lc3b_word      pc_mem   [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          push;
    logic          pop;
    lc3b_word      head_word;
    lc3b_ir_fields head_fields;
    lc3b_ir_fields shown;

    // Handshake qualification; fullness and emptiness come from count alone.
    always_comb begin
        in_ready  = (count != CW'(DEPTH)) && !flush;
        out_valid = (count != '0);
        push      = in_valid && in_ready;
        pop       = out_valid && out_ready;
    end

    // Storage write port; contents are don't-care until a push lands.
    always_ff @(posedge clk) begin
        if (push) begin
            word_mem[wr_ptr] <= in_word;
            pc_mem[wr_ptr]   <= in_pc;
        end
    end

    // Pointer and occupancy update; flush overrides any same-cycle push or pop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + PW'(1);
            if (pop)
                rd_ptr <= rd_ptr + PW'(1);
            if (push && !pop)
                count <= count + CW'(1);
            else if (pop && !push)
                count <= count - CW'(1);
        end
    end

    assign head_word = word_mem[rd_ptr];

    ir_decode #(
        .SEXT (SEXT)
    ) u_decode (
        .word   (head_word),
        .fields (head_fields)
    );

    // Blank every head output while the queue is empty.
    always_comb begin
        shown  = out_valid ? head_fields : '0;
        out_pc = out_valid ? pc_mem[rd_ptr] : '0;
    end

    assign opcode   = shown.opcode;
    assign dest     = shown.dest;
    assign src1     = shown.src1;
    assign src2     = shown.src2;
    assign imm_mode = shown.imm_mode;
    assign offset4  = shown.offset4;
    assign offset8  = shown.offset8;
    assign offset5  = shown.offset5;
    assign offset6  = shown.offset6;
    assign offset9  = shown.offset9;
    assign offset11 = shown.offset11;

endmodule
